accel_host_driver: RTL and testbench
====================================

Name: accel_host_driver

Overview:
- Hardware stand-in for the ARM side of the accelerator command/BRAM protocol. It drives port1 commands, supplies bram_din, consumes bram_dout and acknowledges port2 "done".
- One job_start runs the fixed sequence CMD_READ (0) -> CMD_COMPUTE (1) -> CMD_WRITE (2) against the accelerator wrapper, then returns the 1024-bit result.
- Used for on-fabric self-test and as the bench-side master in system simulation.

Parameters:
- DATA_W, 1024, width of the BRAM data chunk.
- CMD_W, 32, width of the port1 command word.
- TIMEOUT_CYCLES, 4096, maximum cycles spent in any single wait state before the job aborts.
- TO_W, 13, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- job_start  in  1  single-cycle request; sampled only in IDLE.
- job_din  in  DATA_W  operand; captured on an accepted job_start.
- job_dout  out  DATA_W  result of the last job; reset 0.
- job_done  out  1  single-cycle pulse at job end (success or abort); reset 0.
- job_error  out  1  high when the last job aborted on timeout; cleared by the next accepted job_start; reset 0.
- job_busy  out  1  high in every state except IDLE; reset 0.
- port1_din  out  CMD_W  command word; reset 0.
- port1_valid  out  1  command valid; reset 0.
- port1_read  in  1  wrapper has consumed the command.
- bram_din  out  DATA_W  operand register contents.
- bram_din_valid  out  1  operand valid; reset 0.
- bram_dout  in  DATA_W  result from the wrapper.
- bram_dout_valid  in  1  result valid.
- bram_dout_read  out  1  single-cycle result acknowledge; reset 0.
- port2_valid  in  1  wrapper "done" flag.
- port2_read  out  1  single-cycle done acknowledge; reset 0.

Behaviour:
- All outputs are registered. Asserting resetn low forces IDLE, clears every output and counter, and drops any in-flight handshake immediately. The wrapper is reset on the same resetn.
- IDLE: on job_start, capture job_din into op_reg, clear job_error, set phase = READ, go to CMD.
- CMD: drive port1_din with the phase code (0/1/2) and hold port1_valid high until port1_read is sampled high. port1_valid deasserts in the following cycle.
  - phase READ -> RD_XFER.
  - phase COMPUTE -> DONE_WAIT.
  - phase WRITE -> WR_XFER.
- RD_XFER: bram_din = op_reg. bram_din_valid is asserted from the cycle after port1_read and held until port2_valid is seen; it deasserts in the same cycle that port2_read pulses. Then go to DONE_WAIT/ACK.
- WR_XFER: on the first cycle bram_dout_valid is high, capture bram_dout into res_reg and pulse bram_dout_read for exactly 1 cycle. A second consecutive bram_dout_valid cycle (the wrapper's registered lag) is ignored. Then go to DONE_WAIT.
- DONE_WAIT: when port2_valid is high, pulse port2_read for 1 cycle and go to DRAIN.
- DRAIN: wait until port2_valid is low. The wrapper's port2_valid lags by one cycle, and this prevents a double acknowledge. Then advance the phase:
  - READ -> COMPUTE, go to CMD.
  - COMPUTE -> WRITE, go to CMD.
  - WRITE -> FINISH.
- FINISH: job_dout <= res_reg, pulse job_done for 1 cycle, go to IDLE.
- Timeout:
  - to_cnt clears on every state entry and increments in CMD, RD_XFER, WR_XFER, DONE_WAIT and DRAIN.
  - When to_cnt reaches TIMEOUT_CYCLES-1: deassert all handshake outputs, set job_error = 1, pulse job_done, go to IDLE. job_dout keeps its previous value.
- job_start while busy is ignored; no queueing.
- Latency on a wrapper that responds immediately: job_start to job_done is 3 commands x (port1 round trip + done round trip) plus accelerator compute time. Expected about 20 cycles plus compute.

Optional Feature:
- HOST_DRV_PERF_CNT_EN defined:
  - Adds output perf_cycles (32-bit), reset 0.
  - The counter clears on an accepted job_start, increments every busy cycle, and freezes at job_done. It saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package accel_proto_pkg holds:
  - CMD_READ = 32'h0, CMD_COMPUTE = 32'h1, CMD_WRITE = 32'h2;
  - the phase enum;
  - the driver state enum;
  - DATA_W.
- The wrapper and this driver both import this package.
- Natural sub-module: accel_host_timeout, a loadable counter with clear/enable/expire outputs, reused across all wait states.

Test Plan:
- Driver + wrapper with an identity accelerator; job_din = 1024'hA5..A5 -> job_done after three commands, job_dout = A5..A5, job_error = 0, exactly 3 port1_read and 3 port2_read pulses.
- Bench wrapper model holds port1_read low forever -> job_done at cycle TIMEOUT_CYCLES after CMD entry, job_error = 1, port1_valid low the following cycle.
- port2_valid held high for 2 cycles after the acknowledge -> exactly one port2_read pulse per phase, with no premature next command.
- bram_dout_valid high for 2 consecutive cycles with different data (X, then Y) -> job_dout = X, one bram_dout_read pulse.
- resetn asserted low during RD_XFER -> all outputs 0 asynchronously; after release, a new job with 1024'h1 completes with job_dout = 1.
- job_start pulsed while job_busy = 1 -> ignored; the first job's result is unaffected and no extra job_done occurs.

Source files
------------

// File: rtl/accel_proto_pkg.sv
// accel_proto_pkg: command codes, phase/state enums and widths shared by the accelerator wrapper and host driver
package accel_proto_pkg;
  localparam int DATA_W = 1024;
  localparam int CMD_W = 32;
  localparam logic [31:0] CMD_READ = 32'h0;
  localparam logic [31:0] CMD_COMPUTE = 32'h1;
  localparam logic [31:0] CMD_WRITE = 32'h2;
  typedef enum logic [1:0] {PH_READ, PH_COMPUTE, PH_WRITE} phase_e;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_RD_XFER, S_WR_XFER, S_DONE_WAIT, S_DRAIN, S_FINISH} drv_state_e;
  function automatic logic [31:0] cmd_of(phase_e p);
    return p == PH_READ ? CMD_READ : p == PH_COMPUTE ? CMD_COMPUTE : CMD_WRITE;
  endfunction
endpackage

// File: rtl/accel_host_if.sv
// accel_host_if: port1 command, BRAM data and port2 done handshakes between host driver (master) and wrapper (slave)
interface accel_host_if #(
  parameter int DATA_W = accel_proto_pkg::DATA_W,
  parameter int CMD_W = accel_proto_pkg::CMD_W
);
  logic [CMD_W-1:0] port1_din;
  logic port1_valid;
  logic port1_read;
  logic [DATA_W-1:0] bram_din;
  logic bram_din_valid;
  logic [DATA_W-1:0] bram_dout;
  logic bram_dout_valid;
  logic bram_dout_read;
  logic port2_valid;
  logic port2_read;
  modport master (
    output port1_din, port1_valid, bram_din, bram_din_valid, bram_dout_read, port2_read,
    input port1_read, bram_dout, bram_dout_valid, port2_valid
  );
  modport slave (
    input port1_din, port1_valid, bram_din, bram_din_valid, bram_dout_read, port2_read,
    output port1_read, bram_dout, bram_dout_valid, port2_valid
  );
endinterface

// File: rtl/accel_host_timeout.sv
// accel_host_timeout: wait-state watchdog counter, cleared on state entry, flags the last permitted cycle
module accel_host_timeout #(
  parameter int LIMIT = 4096,
  parameter int W = 13
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [W-1:0] cnt_q;
  // Count cycles spent in the current wait state.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else cnt_q <= clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  assign expired = en && cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/accel_host_driver.sv
// accel_host_driver: runs READ/COMPUTE/WRITE against the accelerator wrapper per job; HOST_DRV_PERF_CNT_EN adds perf_cycles
module accel_host_driver #(
  parameter int DATA_W = accel_proto_pkg::DATA_W,
  parameter int CMD_W = accel_proto_pkg::CMD_W,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W = 13
) (
  input  logic clk,
  input  logic resetn,
  input  logic job_start,
  input  logic [DATA_W-1:0] job_din,
  output logic [DATA_W-1:0] job_dout,
  output logic job_done,
  output logic job_error,
  output logic job_busy,
`ifdef HOST_DRV_PERF_CNT_EN
  output logic [31:0] perf_cycles,
`endif
  accel_host_if.master bus
);
  import accel_proto_pkg::*;
  drv_state_e state_q;
  phase_e phase_q, ph_nx;
  logic [DATA_W-1:0] op_q, res_q;
  logic waiting, step, expired, accept;
  assign waiting = state_q inside {S_CMD, S_RD_XFER, S_WR_XFER, S_DONE_WAIT, S_DRAIN};
  assign accept = state_q == S_IDLE && job_start;
  assign ph_nx = phase_q == PH_READ ? PH_COMPUTE : PH_WRITE;
  assign bus.bram_din = op_q;
  // The handshake event that ends the current wait state.
  always_comb
    step = state_q == S_CMD ? bus.port1_read :
           (state_q == S_RD_XFER || state_q == S_DONE_WAIT) ? bus.port2_valid :
           state_q == S_WR_XFER ? bus.bram_dout_valid :
           state_q == S_DRAIN ? !bus.port2_valid : 1'b0;
  accel_host_timeout #(.LIMIT(TIMEOUT_CYCLES), .W(TO_W)) u_to (
    .clk(clk), .resetn(resetn), .clr(!waiting || step), .en(waiting), .expired(expired)
  );
  // Job sequencer; a timeout overrides any handshake in the same cycle.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= S_IDLE;
      phase_q <= PH_READ;
      op_q <= '0;
      res_q <= '0;
      job_dout <= '0;
      job_done <= 1'b0;
      job_error <= 1'b0;
      job_busy <= 1'b0;
      bus.port1_din <= '0;
      bus.port1_valid <= 1'b0;
      bus.bram_din_valid <= 1'b0;
      bus.bram_dout_read <= 1'b0;
      bus.port2_read <= 1'b0;
    end else begin
      job_done <= 1'b0;
      bus.bram_dout_read <= 1'b0;
      bus.port2_read <= 1'b0;
      if (expired) begin
        bus.port1_valid <= 1'b0;
        bus.bram_din_valid <= 1'b0;
        job_error <= 1'b1;
        job_done <= 1'b1;
        job_busy <= 1'b0;
        state_q <= S_IDLE;
      end else case (state_q)
        S_IDLE: if (accept) begin
          op_q <= job_din;
          job_error <= 1'b0;
          job_busy <= 1'b1;
          phase_q <= PH_READ;
          bus.port1_din <= CMD_W'(CMD_READ);
          bus.port1_valid <= 1'b1;
          state_q <= S_CMD;
        end
        S_CMD: if (step) begin
          bus.port1_valid <= 1'b0;
          bus.bram_din_valid <= phase_q == PH_READ;
          state_q <= phase_q == PH_READ ? S_RD_XFER : phase_q == PH_COMPUTE ? S_DONE_WAIT : S_WR_XFER;
        end
        S_RD_XFER: if (step) begin
          bus.bram_din_valid <= 1'b0;
          bus.port2_read <= 1'b1;
          state_q <= S_DRAIN;
        end
        S_WR_XFER: if (step) begin
          res_q <= bus.bram_dout;
          bus.bram_dout_read <= 1'b1;
          state_q <= S_DONE_WAIT;
        end
        S_DONE_WAIT: if (step) begin
          bus.port2_read <= 1'b1;
          state_q <= S_DRAIN;
        end
        S_DRAIN: if (step) begin
          if (phase_q == PH_WRITE) state_q <= S_FINISH;
          else begin
            phase_q <= ph_nx;
            bus.port1_din <= CMD_W'(cmd_of(ph_nx));
            bus.port1_valid <= 1'b1;
            state_q <= S_CMD;
          end
        end
        S_FINISH: begin
          job_dout <= res_q;
          job_done <= 1'b1;
          job_busy <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
`ifdef HOST_DRV_PERF_CNT_EN
  // Busy-cycle counter: cleared on an accepted job, saturating, frozen while idle.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) perf_cycles <= '0;
    else if (accept) perf_cycles <= '0;
    else if (job_busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
`endif
endmodule

// File: tb/tb_accel_host_driver.sv
// tb_accel_host_driver: randomized jobs against a bench wrapper model, scoreboarded at job_done
module tb_accel_host_driver;
  import accel_proto_pkg::*;
  localparam int DW = 1024, TO = 64, TW = 7, LIM = 200;
  typedef struct {
    logic [DW-1:0] dout;
    logic err;
    int p2;
    int bdr;
  } exp_t;
  logic clk = 1'b0, resetn = 1'b0, job_start = 1'b0;
  logic [DW-1:0] job_din = '0, job_dout, last_dout = '0;
  logic job_done, job_error, job_busy;
`ifdef HOST_DRV_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif
  int n_cmp = 0, n_bad = 0, cyc = 0, p2_cnt = 0, bdr_cnt = 0, bc = 0;
  exp_t sb[$];
  exp_t e;
  accel_host_if #(.DATA_W(DW), .CMD_W(32)) bus ();
  accel_host_driver #(.DATA_W(DW), .CMD_W(32), .TIMEOUT_CYCLES(TO), .TO_W(TW)) dut (
    .clk(clk), .resetn(resetn), .job_start(job_start), .job_din(job_din),
    .job_dout(job_dout), .job_done(job_done), .job_error(job_error), .job_busy(job_busy),
`ifdef HOST_DRV_PERF_CNT_EN
    .perf_cycles(perf_cycles),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (low 128 bits, %0d bits differ)", name, act[127:0], exp[127:0], $countones(act ^ exp));
    end
  endtask
  function automatic logic sig(input int id);
    case (id)
      0: return bus.port1_valid;
      1: return bus.bram_din_valid;
      2: return bus.port2_read;
      default: return job_done;
    endcase
  endfunction
  task automatic wait_for(input int id, input string name);
    int n = 0;
    while (!sig(id) && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (!sig(id)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_%s: still low after %0d cycles, want high", name, LIM);
    end
  endtask
  function automatic logic [DW-1:0] rnd_wide();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction
  // Monitor: pulse counts per job, compared with the scoreboard at every job_done.
  always @(negedge clk) begin
    if (!resetn) begin
      p2_cnt = 0;
      bdr_cnt = 0;
      bc = 0;
    end else begin
      p2_cnt += int'(bus.port2_read);
      bdr_cnt += int'(bus.bram_dout_read);
      if (job_done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_done: got job_done with no job outstanding, want none");
        end else begin
          e = sb.pop_front();
          chk("job_dout", job_dout, e.dout);
          chk("job_error", DW'(job_error), DW'(e.err));
          chk("port2_read_pulses", DW'(p2_cnt), DW'(e.p2));
          chk("bram_dout_read_pulses", DW'(bdr_cnt), DW'(e.bdr));
`ifdef HOST_DRV_PERF_CNT_EN
          chk("perf_cycles", DW'(perf_cycles), DW'(bc));
`endif
        end
        p2_cnt = 0;
        bdr_cnt = 0;
      end
      bc = job_busy ? bc + 1 : 0;
    end
  end
  task automatic p2_hs(input int hold, input bit is_read);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.port2_valid = 1'b1;
    wait_for(2, "port2_read");
    if (is_read) chk("bram_din_valid_drop", DW'(bus.bram_din_valid), '0);
    repeat (hold) begin
      @(negedge clk);
      chk("no_early_cmd", DW'(bus.port1_valid), '0);
    end
    bus.port2_valid = 1'b0;
  endtask
  task automatic serve_cmd(input logic [31:0] want, input logic [DW-1:0] din, input logic [DW-1:0] res,
                           input int hold, input bit dbl);
    wait_for(0, "port1_valid");
    chk("port1_din", DW'(bus.port1_din), DW'(want));
    repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.port1_read = 1'b1;
    @(negedge clk);
    bus.port1_read = 1'b0;
    chk("port1_valid_drop", DW'(bus.port1_valid), '0);
    if (want == CMD_READ) begin
      wait_for(1, "bram_din_valid");
      chk("bram_din", bus.bram_din, din);
      p2_hs(hold, 1'b1);
    end else if (want == CMD_COMPUTE) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      p2_hs(hold, 1'b0);
    end else begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.bram_dout = res;
      bus.bram_dout_valid = 1'b1;
      @(negedge clk);
      if (dbl) begin
        bus.bram_dout = rnd_wide();
        @(negedge clk);
      end
      bus.bram_dout_valid = 1'b0;
      p2_hs(hold, 1'b0);
    end
  endtask
  task automatic run_job(input logic [DW-1:0] din, input logic [DW-1:0] mask, input int hold,
                         input bit dbl, input bit stall);
    exp_t x;
    int c0;
    logic [DW-1:0] res = din ^ mask;
    x.dout = stall ? last_dout : res;
    x.err = stall;
    x.p2 = stall ? 0 : 3;
    x.bdr = stall ? 0 : 1;
    sb.push_back(x);
    @(negedge clk);
    job_din = din;
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    job_din = rnd_wide();
    if (stall) begin
      wait_for(0, "port1_valid");
      c0 = cyc;
      wait_for(3, "job_done");
      chk("timeout_latency", DW'(cyc - c0), DW'(TO));
      chk("port1_valid_after_timeout", DW'(bus.port1_valid), '0);
    end else begin
      serve_cmd(CMD_READ, din, res, hold, dbl);
      serve_cmd(CMD_COMPUTE, din, res, hold, dbl);
      serve_cmd(CMD_WRITE, din, res, hold, dbl);
      wait_for(3, "job_done");
      last_dout = res;
    end
    @(negedge clk);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time limit, want finished");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.port1_read = 1'b0;
    bus.bram_dout = '0;
    bus.bram_dout_valid = 1'b0;
    bus.port2_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_job_dout", job_dout, '0);
    chk("reset_flags", DW'({job_done, job_error, job_busy, bus.port1_valid, bus.bram_din_valid,
                            bus.bram_dout_read, bus.port2_read}), '0);
    resetn = 1'b1;
    run_job({128{8'hA5}}, '0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) run_job(rnd_wide(), rnd_wide(), $urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'b0);
    run_job(rnd_wide(), rnd_wide(), 1, 1'b0, 1'b1);
    run_job(rnd_wide(), rnd_wide(), 3, 1'b0, 1'b0);
    run_job(rnd_wide(), '0, 1, 1'b1, 1'b0);
    fork
      run_job(rnd_wide(), rnd_wide(), 1, 1'b0, 1'b0);
      begin
        repeat (6) @(negedge clk);
        chk("busy_before_extra_start", DW'(job_busy), DW'(1));
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    @(negedge clk);
    job_din = rnd_wide();
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    wait_for(0, "port1_valid");
    bus.port1_read = 1'b1;
    @(negedge clk);
    bus.port1_read = 1'b0;
    chk("rd_xfer_entered", DW'(bus.bram_din_valid), DW'(1));
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_job_dout", job_dout, '0);
    chk("async_reset_bram_din", bus.bram_din, '0);
    chk("async_reset_flags", DW'({bus.port1_din, job_done, job_error, job_busy, bus.port1_valid,
                                  bus.bram_din_valid, bus.bram_dout_read, bus.port2_read}), '0);
    last_dout = '0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    run_job(DW'(1), '0, 1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", DW'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
